// File: rtl/axis_rr_arbiter4.sv
// axis_rr_arbiter4 -- four-input AXI-Stream packet arbiter with round-robin
// grant and a two-entry registered output FIFO.
// Packet boundaries are respected: once a port wins it keeps the grant until
// its tlast beat is accepted. Each IDLE arbitration cycle inserts one bubble
// between packets.
// Optional feature macro: ARB_PKT_CNT_EN enables the four 16-bit per-port
// packet counters on pkt_cnt. When it is undefined, pkt_cnt is tied to zero.
module axis_rr_arbiter4 #(
  parameter int DATA_W = 32
) (
  input  logic                  axis_aclk,
  input  logic                  axis_areset,
  input  logic [4*DATA_W-1:0]   s_axis_tdata,
  input  logic [3:0]            s_axis_tvalid,
  output logic [3:0]            s_axis_tready,
  input  logic [3:0]            s_axis_tlast,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [1:0]            m_axis_tid,
  output logic                  busy,
  output logic [63:0]           pkt_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  genvar gi;

  logic [0:0]        state_reg;
  logic [1:0]        ptr_reg;
  logic [1:0]        grant_reg;

  // Slot 0 is the head and drives m_axis directly. Slot 1 holds the second beat.
  logic              head_valid_reg;
  logic [DATA_W-1:0] head_data_reg;
  logic              head_last_reg;
  logic [1:0]        head_tid_reg;
  logic              tail_valid_reg;
  logic [DATA_W-1:0] tail_data_reg;
  logic              tail_last_reg;
  logic [1:0]        tail_tid_reg;

  logic [DATA_W-1:0] s_data [4];
  logic              fifo_full;
  logic              accept;
  logic              pop;
  logic              grant_last;
  logic              pick_found;
  logic [1:0]        pick_idx;

  generate
    for (gi = 0; gi < 4; gi++) begin : gen_unpack
      assign s_data[gi] = s_axis_tdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign fifo_full  = head_valid_reg & tail_valid_reg;
  assign grant_last = s_axis_tlast[grant_reg];
  assign accept     = (state_reg == ST_LOCK) & s_axis_tvalid[grant_reg] & ~fifo_full;
  assign pop        = head_valid_reg & m_axis_tready;
  assign busy       = (state_reg == ST_LOCK);

  assign m_axis_tvalid = head_valid_reg;
  assign m_axis_tdata  = head_data_reg;
  assign m_axis_tlast  = head_last_reg;
  assign m_axis_tid    = head_tid_reg;

  // Round-robin search: the first valid port at or after ptr wins.
  always_comb begin
    logic [1:0] cand;
    pick_found = 1'b0;
    pick_idx   = ptr_reg;
    cand       = ptr_reg;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_reg + 2'(k);
      if (!pick_found && s_axis_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Only the granted port sees ready. It is held off while the output FIFO is full.
  always_comb begin
    s_axis_tready = 4'b0000;
    if (state_reg == ST_LOCK) begin
      s_axis_tready[grant_reg] = ~fifo_full;
    end
  end

  // Grant FSM: lock onto a port in IDLE, and release it after the accepted tlast beat.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= 2'd0;
      grant_reg <= 2'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_found) begin
            state_reg <= ST_LOCK;
            grant_reg <= pick_idx;
          end
        end
        default: begin
          if (accept && grant_last) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= grant_reg + 2'd1;
          end
        end
      endcase
    end
  end

  // Two-entry output FIFO. A push and a pop together are only possible with
  // one entry present, so the head is simply replaced in that case.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
      head_last_reg  <= 1'b0;
      head_tid_reg   <= 2'd0;
      tail_valid_reg <= 1'b0;
      tail_data_reg  <= '0;
      tail_last_reg  <= 1'b0;
      tail_tid_reg   <= 2'd0;
    end else if (pop) begin
      if (tail_valid_reg) begin
        head_data_reg  <= tail_data_reg;
        head_last_reg  <= tail_last_reg;
        head_tid_reg   <= tail_tid_reg;
        tail_valid_reg <= 1'b0;
      end else if (accept) begin
        head_data_reg  <= s_data[grant_reg];
        head_last_reg  <= grant_last;
        head_tid_reg   <= grant_reg;
      end else begin
        head_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      if (!head_valid_reg) begin
        head_valid_reg <= 1'b1;
        head_data_reg  <= s_data[grant_reg];
        head_last_reg  <= grant_last;
        head_tid_reg   <= grant_reg;
      end else begin
        tail_valid_reg <= 1'b1;
        tail_data_reg  <= s_data[grant_reg];
        tail_last_reg  <= grant_last;
        tail_tid_reg   <= grant_reg;
      end
    end
  end

`ifdef ARB_PKT_CNT_EN
  generate
    for (gi = 0; gi < 4; gi++) begin : gen_cnt
      logic [15:0] cnt_reg;
      // Count every accepted end-of-packet beat from this port. The counter wraps naturally.
      always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
          cnt_reg <= 16'd0;
        end else if (accept && grant_last && (grant_reg == 2'(gi))) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
      assign pkt_cnt[16*gi +: 16] = cnt_reg;
    end
  endgenerate
`else
  assign pkt_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter4.sv
// tb_axis_rr_arbiter4 -- directed bench for the four-port round-robin AXIS arbiter.
// A table of simultaneous-packet scenarios is applied first. Hand-written
// sequences then cover the mid-packet, backpressure, single-beat,
// reset and counter cases.
module tb_axis_rr_arbiter4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b0;
  logic [4*DW-1:0]   s_tdata = '0;
  logic [3:0]        s_tvalid = '0;
  logic [3:0]        s_tready;
  logic [3:0]        s_tlast = '0;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tready = 1'b0;
  logic              m_tlast;
  logic [1:0]        m_tid;
  logic              busy;
  logic [63:0]       pkt_cnt;

  axis_rr_arbiter4 #(.DATA_W(DW)) dut (
    .axis_aclk     (clk),
    .axis_areset   (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tid    (m_tid),
    .busy          (busy),
    .pkt_cnt       (pkt_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Per-port source memories hold {tlast, tdata} beats still to be offered.
  logic [DW:0]   src_mem [4][32];
  int            src_wr [4];
  int            src_rd [4];
  logic [3:0]    src_en;
  logic          m_ready;
  logic [3:0]    fire_p;
  logic          mfire_p;
  logic [DW+2:0] cap;
  logic [DW+2:0] out_beat [$];
  int            out_cyc [$];
  int            cyc = 0;

  typedef struct {
    logic [3:0] mask;
    int         len;
    int         npk;
    logic [7:0] order;
  } vec_t;
  vec_t vt [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (src_en[i] && src_rd[i] < src_wr[i]) begin
        s_tvalid[i] = 1'b1;
        s_tlast[i]  = src_mem[i][src_rd[i]][DW];
        s_tdata[i*DW +: DW] = src_mem[i][src_rd[i]][DW-1:0];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
        s_tdata[i*DW +: DW] = '0;
      end
    end
    m_tready = m_ready;
  endtask

  // One clock cycle: first book the handshakes from the last rising edge, then drive new values and sample.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) if (fire_p[i]) src_rd[i]++;
    if (mfire_p) begin
      out_beat.push_back(cap);
      out_cyc.push_back(cyc);
    end
    drive();
    #1;
    fire_p  = s_tvalid & s_tready;
    mfire_p = m_tvalid & m_tready;
    cap     = {m_tid, m_tlast, m_tdata};
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    src_en  = 4'b0000;
    fire_p  = 4'b0000;
    mfire_p = 1'b0;
    out_beat.delete();
    out_cyc.delete();
    drive();
  endtask

  task automatic load(input int p, input int n, input logic [31:0] base);
    for (int b = 0; b < n; b++) begin
      if (src_wr[p] < 32) begin
        src_mem[p][src_wr[p]] = {(b == n - 1), base + 32'(b)};
        src_wr[p]++;
      end
    end
  endtask

  // Assert reset without waiting for a clock edge, confirm the reset values, then release it on a falling edge.
  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    clear_all();
    #1;
    check({tag, ".m_tvalid"}, 64'(m_tvalid), 64'd0);
    check({tag, ".m_tlast"},  64'(m_tlast),  64'd0);
    check({tag, ".m_tid"},    64'(m_tid),    64'd0);
    check({tag, ".busy"},     64'(busy),     64'd0);
    check({tag, ".s_tready"}, 64'(s_tready), 64'd0);
    check({tag, ".pkt_cnt"},  pkt_cnt,       64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic run_until_out(input string tag, input int n);
    int t;
    t = 0;
    while (out_beat.size() < n && t < 300) begin
      step();
      t++;
    end
    check({tag, ".beat_count"}, 64'(out_beat.size()), 64'(n));
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [1:0] tid,
                            input logic last, input logic [31:0] data);
    logic [DW+2:0] b;
    b = '0;
    if (idx < out_beat.size()) b = out_beat[idx];
    check($sformatf("%s.beat[%0d]", tag, idx), 64'(b), 64'({tid, last, data}));
  endtask

  task automatic check_gap(input string tag, input int idx, input int gap);
    int d;
    d = -1;
    if (idx < out_cyc.size() && idx > 0) d = out_cyc[idx] - out_cyc[idx-1];
    check($sformatf("%s.gap[%0d]", tag, idx), 64'(d), 64'(gap));
  endtask

  function automatic logic [31:0] base_of(input int p);
    return 32'((p + 1) << 8);
  endfunction

  function automatic logic [63:0] exp_cnt(input logic [3:0] mask);
    logic [63:0] r;
    r = '0;
`ifdef ARB_PKT_CNT_EN
    for (int p = 0; p < 4; p++) if (mask[p]) r[16*p +: 16] = 16'd1;
`else
    r = {60'd0, mask & 4'b0000};
`endif
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [DW+2:0] held;
    // The order field is packed {4th,3rd,2nd,1st} 2-bit tids.
    vt[0] = '{4'b1111, 3, 4, {2'd3, 2'd2, 2'd1, 2'd0}};
    vt[1] = '{4'b1010, 2, 2, {2'd0, 2'd0, 2'd3, 2'd1}};
    vt[2] = '{4'b0100, 1, 1, {2'd0, 2'd0, 2'd0, 2'd2}};
    vt[3] = '{4'b1001, 1, 2, {2'd0, 2'd0, 2'd3, 2'd0}};
    vt[4] = '{4'b0110, 4, 2, {2'd0, 2'd0, 2'd2, 2'd1}};

    m_ready = 1'b1;
    clear_all();
    #2;
    reset_pulse("init_rst");

    // Table: all packets are presented at once after reset, and the grant order is checked.
    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      reset_pulse({tag, ".rst"});
      m_ready = 1'b1;
      for (int p = 0; p < 4; p++) if (vt[v].mask[p]) load(p, vt[v].len, base_of(p));
      src_en = vt[v].mask;
      run_until_out(tag, vt[v].npk * vt[v].len);
      for (int k = 0; k < vt[v].npk; k++) begin
        logic [1:0] tid;
        tid = vt[v].order[2*k +: 2];
        for (int b = 0; b < vt[v].len; b++) begin
          int idx;
          idx = k * vt[v].len + b;
          check_beat(tag, idx, tid, (b == vt[v].len - 1), base_of(int'(tid)) + 32'(b));
          if (idx > 0) check_gap(tag, idx, (b == 0) ? 2 : 1);
        end
      end
      repeat (3) step();
      check({tag, ".no_extra"}, 64'(out_beat.size()), 64'(vt[v].npk * vt[v].len));
      check({tag, ".pkt_cnt"}, pkt_cnt, exp_cnt(vt[v].mask));
    end

    // Port 2 mid-packet while port 1 becomes valid.
    reset_pulse("midpkt.rst");
    m_ready = 1'b1;
    load(2, 5, 32'hA0);
    src_en = 4'b0100;
    t = 0;
    while (src_rd[2] < 2 && t < 20) begin step(); t++; end
    check("midpkt.reach", 64'(src_rd[2]), 64'd2);
    load(1, 2, 32'hB0);
    src_en = 4'b0110;
    t = 0;
    while (src_rd[2] < 5 && t < 20) begin
      step();
      t++;
      check($sformatf("midpkt.tready1_c%0d", t), 64'(s_tready[1]), 64'd0);
    end
    run_until_out("midpkt", 7);
    for (int b = 0; b < 5; b++) begin
      check_beat("midpkt", b, 2'd2, (b == 4), 32'hA0 + 32'(b));
      if (b > 0) check_gap("midpkt", b, 1);
    end
    check_beat("midpkt", 5, 2'd1, 1'b0, 32'hB0);
    check_beat("midpkt", 6, 2'd1, 1'b1, 32'hB1);

    // Output stall during a port-0 packet.
    reset_pulse("stall.rst");
    m_ready = 1'b1;
    load(0, 8, 32'hC0);
    src_en = 4'b0001;
    run_until_out("stall.pre", 2);
    m_ready = 1'b0;
    held = '0;
    for (int s = 1; s <= 10; s++) begin
      step();
      if (s == 1) held = {m_tid, m_tlast, m_tdata};
      check($sformatf("stall.m_tvalid_s%0d", s), 64'(m_tvalid), 64'd1);
      if (s > 1) check($sformatf("stall.hold_s%0d", s), 64'({m_tid, m_tlast, m_tdata}), 64'(held));
      if (s >= 3) begin
        check($sformatf("stall.tready0_s%0d", s), 64'(s_tready[0]), 64'd0);
        check($sformatf("stall.occupancy_s%0d", s), 64'(src_rd[0] - out_beat.size()), 64'd2);
      end
    end
    m_ready = 1'b1;
    run_until_out("stall", 8);
    for (int b = 0; b < 8; b++) check_beat("stall", b, 2'd0, (b == 7), 32'hC0 + 32'(b));

    // Back-to-back single-beat packets from port 3, then the pointer wraps back to port 0.
    reset_pulse("single.rst");
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) load(3, 1, 32'hD0 + 32'(k));
    src_en = 4'b1000;
    run_until_out("single", 4);
    for (int k = 0; k < 4; k++) begin
      check_beat("single", k, 2'd3, 1'b1, 32'hD0 + 32'(k));
      if (k > 0) check_gap("single", k, 2);
    end
    load(0, 1, 32'hE0);
    load(1, 1, 32'hE1);
    src_en = 4'b1011;
    run_until_out("wrap", 6);
    check_beat("wrap", 4, 2'd0, 1'b1, 32'hE0);
    check_beat("wrap", 5, 2'd1, 1'b1, 32'hE1);

    // Reset asserted while beat 2 of a 4-beat port-1 packet is being offered.
    reset_pulse("rstmid.rst0");
    m_ready = 1'b1;
    load(1, 4, 32'hF0);
    src_en = 4'b0010;
    t = 0;
    while (src_rd[1] < 1 && t < 20) begin step(); t++; end
    check("rstmid.reach", 64'(src_rd[1]), 64'd1);
    check("rstmid.busy", 64'(busy), 64'd1);
    #2;
    reset_pulse("rstmid.rst");
    load(0, 2, 32'h50);
    load(1, 2, 32'h60);
    src_en = 4'b0011;
    run_until_out("rstmid", 4);
    check_beat("rstmid", 0, 2'd0, 1'b0, 32'h50);
    check_beat("rstmid", 1, 2'd0, 1'b1, 32'h51);
    check_beat("rstmid", 2, 2'd1, 1'b0, 32'h60);
    check_beat("rstmid", 3, 2'd1, 1'b1, 32'h61);

`ifdef ARB_PKT_CNT_EN
    // Preset port 1 to 0xFFFF. One more packet must wrap it to 0.
    reset_pulse("cnt.rst");
    m_ready = 1'b1;
    dut.gen_cnt[1].cnt_reg = 16'hFFFF;
    load(1, 1, 32'h77);
    src_en = 4'b0010;
    run_until_out("cnt", 1);
    check("cnt.port1_wrap", 64'(pkt_cnt[31:16]), 64'h0);
    load(2, 2, 32'h88);
    src_en = 4'b0110;
    run_until_out("cnt2", 3);
    check("cnt.all", pkt_cnt, 64'h0000_0001_0000_0000);
`else
    check("cnt.disabled", pkt_cnt, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter4.md
AXIS_RR_ARBITER4 -- requirements
Module: axis_rr_arbiter4

Interface
REQ-001 SHALL have parameter: DATA_W, 32, tdata width of every input and output stream.
REQ-002 SHALL have port: axis_aclk  input  1  the only clock; all logic is rising-edge.
REQ-003 SHALL have port: axis_areset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: s_axis_tdata  input  4*DATA_W  input data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-005 SHALL have port: s_axis_tvalid  input  4  per-port valid.
REQ-006 SHALL have port: s_axis_tready  output  4  per-port ready.
REQ-007 SHALL have port: s_axis_tlast  input  4  per-port end-of-packet.
REQ-008 SHALL have port: m_axis_tdata  output  DATA_W  merged output data.
REQ-009 SHALL have port: m_axis_tvalid  output  1  output valid.
REQ-010 SHALL have port: m_axis_tready  input  1  output ready.
REQ-011 SHALL have port: m_axis_tlast  output  1  output end-of-packet.
REQ-012 SHALL have port: m_axis_tid  output  2  source port index of the current output beat.
REQ-013 SHALL have port: busy  output  1  high while a grant is held (LOCK state).
REQ-014 SHALL have port: pkt_cnt  output  64  four 16-bit per-port packet counters; port i occupies bits [16*i +: 16].

Function
REQ-015 SHALL implement a two-state FSM: IDLE (no grant) and LOCK (grant g held).
REQ-016 In IDLE with any s_axis_tvalid high, the FSM SHALL move to LOCK the next cycle with g = the first valid port found searching ptr, ptr+1, ... modulo 4.
REQ-017 In IDLE with no valid port, the FSM SHALL stay in IDLE and s_axis_tready SHALL be 4'b0000.
REQ-018 In LOCK, s_axis_tready[g] SHALL equal "output buffer not full" and all other tready bits SHALL be 0.
REQ-019 A beat SHALL be accepted on port g when s_axis_tvalid[g] and s_axis_tready[g] are both high.
REQ-020 When an accepted beat has tlast=1, the FSM SHALL return to IDLE and ptr SHALL become (g+1) mod 4.
REQ-021 Grant SHALL never change mid-packet, regardless of tvalid activity on other ports.
REQ-022 The output SHALL be a 2-entry FIFO storing {tid, tlast, tdata}; all m_axis_* outputs SHALL come directly from registers.
REQ-023 An accepted beat SHALL appear on m_axis at the earliest one cycle after acceptance.
REQ-024 Sustained throughput SHALL be 1 beat/cycle inside a packet, with a 1-cycle bubble between packets (the IDLE arbitration cycle).
REQ-025 Simultaneous push and pop with the FIFO full SHALL be impossible, because tready is low when full; a push and pop with 1 entry present SHALL leave the count at 1.
REQ-026 With m_axis_tready low, the FIFO SHALL fill to 2 and then deassert s_axis_tready[g]; no beat SHALL be lost or duplicated.
REQ-027 m_axis_tdata/tlast/tid SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-028 Single-beat packets (tvalid with tlast=1 on the first beat) SHALL be granted and released normally.

Reset
REQ-029 On axis_areset high, the block SHALL asynchronously enter IDLE with ptr=0 and the FIFO empty.
REQ-030 During reset, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tid=0, busy=0, s_axis_tready=0 and pkt_cnt=0 SHALL hold.
REQ-031 Reset asserted mid-packet SHALL discard the partial packet and any buffered beats.
REQ-032 After reset release, port 0 SHALL have the highest priority for the first grant.

Configuration
REQ-033 Macro ARB_PKT_CNT_EN SHALL control packet counting.
REQ-034 When ARB_PKT_CNT_EN is defined, pkt_cnt[16*i +: 16] SHALL increment by 1 on each accepted tlast beat on port i, wrapping from 0xFFFF to 0x0000.
REQ-035 When ARB_PKT_CNT_EN is not defined, pkt_cnt SHALL be driven constant 0 and no counter registers SHALL be built.

Verification
REQ-036 Bench SHALL cover: ports 0-3 each hold a 3-beat packet valid at once, m_tready=1 -> output order tid 0,1,2,3, 12 beats, one bubble between packets.
REQ-037 Bench SHALL cover: port 2 is mid-packet (tdata 0xA0..0xA4) while port 1 asserts tvalid -> all 5 port-2 beats are output contiguously before any port-1 beat, and tready[1]=0 throughout.
REQ-038 Bench SHALL cover: m_tready=0 for 10 cycles during a port-0 packet -> m_tvalid=1 with stable data, FIFO holds 2, tready[0]=0, and the data sequence is intact after release.
REQ-039 Bench SHALL cover: only port 3 sends single-beat packets back-to-back -> each is granted, ptr wraps to 0, tid=3 on every output beat.
REQ-040 Bench SHALL cover: reset pulse during beat 2 of a 4-beat port-1 packet -> outputs reach reset values immediately, and the next grant is port 0 if valid.
REQ-041 Bench SHALL cover: with ARB_PKT_CNT_EN, preload 65535 packets on port 1 and send one more -> pkt_cnt[31:16] reads 0x0000; without the macro, pkt_cnt stays 0.
